aes128_decrypt_iter: RTL and testbench

Iterative AES-128 decryption core, the receive-side counterpart of the `AES128` pipelined encryptor. It accepts one 128-bit ciphertext block and one 128-bit cipher key per transaction over a valid/ready handshake. It expands the key forward to round key 10, then runs the FIPS-197 inverse cipher one round per clock, generating round keys backwards on the fly. It trades the encryptor's full unrolling for area: one InvSubBytes/InvShiftRows/InvMixColumns datapath plus one key-schedule unit.

---
 rtl/aes128_decrypt_iter_if.sv | 27 ++
 rtl/aes128_decrypt_iter.sv | 166 ++++++++++++++++
 tb/tb_aes128_decrypt_iter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_decrypt_iter_if.sv
// Block/key in, plaintext out handshake bundle for the iterative AES-128 decryptor.
// master = block source and result sink, slave = the core.
interface aes128_decrypt_iter_if;
  logic [31:0] IN_DATA0, IN_DATA1, IN_DATA2, IN_DATA3;
  logic [31:0] IN_KEY0, IN_KEY1, IN_KEY2, IN_KEY3;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output IN_DATA0, IN_DATA1, IN_DATA2, IN_DATA3,
    output IN_KEY0, IN_KEY1, IN_KEY2, IN_KEY3,
    output in_valid, out_ready,
    input  in_ready, out_valid,
    input  OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3
  );

  modport slave (
    input  IN_DATA0, IN_DATA1, IN_DATA2, IN_DATA3,
    input  IN_KEY0, IN_KEY1, IN_KEY2, IN_KEY3,
    input  in_valid, out_ready,
    output in_ready, out_valid,
    output OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3
  );
endinterface

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor: expands the key forward to rk10, then runs one
// inverse-cipher round per clock while regenerating round keys backwards.
module aes128_decrypt_iter (
  input  logic                 clk,
  input  logic                 reset_n,
  aes128_decrypt_iter_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for a block, in_ready high
  // KEXP  | forward expansion rk1..rk10, initial AddRoundKey on the last step
  // ROUND | one inverse round per cycle, round key stepped backwards
  // DONE  | result presented until out_ready
  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  state_t       state, state_nxt;
  logic [127:0] state_reg, key_reg, out_reg;
  logic [3:0]   rnd;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // byte i sits at bits [127-8i -: 8], column-major; row r rotates right by r
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r)&3)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    end
    return o;
  endfunction

  logic [31:0]  kw0, kw1, kw2, kw3, sw_in, sw_out, rc_word, fw0, fw1, fw2, fw3;
  logic [127:0] fwd_key, inv_key, rnd_out;

  // one SubWord unit shared: w3 going forward, recovered w3 (w3^w2) going backward
  assign {kw0, kw1, kw2, kw3} = key_reg;
  assign rc_word = {rcon(rnd), 24'h000000};
  assign sw_in   = (state == ROUND) ? (kw3 ^ kw2) : kw3;
  assign sw_out  = {sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0]), sbox(sw_in[31:24])};
  assign fw0     = kw0 ^ sw_out ^ rc_word;
  assign fw1     = kw1 ^ fw0;
  assign fw2     = kw2 ^ fw1;
  assign fw3     = kw3 ^ fw2;
  assign fwd_key = {fw0, fw1, fw2, fw3};
  assign inv_key = {kw0 ^ sw_out ^ rc_word, kw1 ^ kw0, kw2 ^ kw1, kw3 ^ kw2};
  assign rnd_out = inv_sub_shift(state_reg) ^ inv_key;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nxt = KEXP;
      KEXP:    if (rnd == 4'd10)  state_nxt = ROUND;
      ROUND:   if (rnd == 4'd1)   state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= '0;
      key_reg   <= '0;
      out_reg   <= '0;
      rnd       <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          state_reg <= {bus.IN_DATA3, bus.IN_DATA2, bus.IN_DATA1, bus.IN_DATA0};
          key_reg   <= {bus.IN_KEY3, bus.IN_KEY2, bus.IN_KEY1, bus.IN_KEY0};
          rnd       <= 4'd1;
        end
        KEXP: begin
          key_reg <= fwd_key;
          if (rnd == 4'd10) begin
            state_reg <= state_reg ^ fwd_key;
            rnd       <= 4'd10;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        ROUND: begin
          key_reg <= inv_key;
          rnd     <= rnd - 4'd1;
          if (rnd == 4'd1) out_reg   <= rnd_out;
          else             state_reg <= inv_mix(rnd_out);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.OUT_DATA3 = out_reg[127:96];
  assign bus.OUT_DATA2 = out_reg[95:64];
  assign bus.OUT_DATA1 = out_reg[63:32];
  assign bus.OUT_DATA0 = out_reg[31:0];
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter: FIPS-197 vectors, handshake timing, backpressure,
// mid-block reset and a random loopback through a forward AES-128 model.
module tb_aes128_decrypt_iter;
  logic clk;
  logic reset_n;
  aes128_decrypt_iter_if bus ();

  aes128_decrypt_iter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [127:0] cur_pt = '0;
  logic [127:0] dout;
  logic [7:0]   sbox [256];

  assign dout = {bus.OUT_DATA3, bus.OUT_DATA2, bus.OUT_DATA1, bus.OUT_DATA0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Forward AES model (used to build ciphertexts and to pin expectations)
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3, tt;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          tt = a0 ^ a1 ^ a2 ^ a3;
          t[4*c]   = a0 ^ tt ^ xt(a0 ^ a1);
          t[4*c+1] = a1 ^ tt ^ xt(a1 ^ a2);
          t[4*c+2] = a2 ^ tt ^ xt(a2 ^ a3);
          t[4*c+3] = a3 ^ tt ^ xt(a3 ^ a0);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Behavioural timing model: accept when idle, result 20 edges later, release on out_ready
  int           m_phase = 0;
  int           m_left  = 0;
  logic [127:0] m_exp   = '0;
  logic [127:0] m_out   = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_out   <= '0;
    end else begin
      case (m_phase)
        0: if (bus.in_valid) begin m_phase <= 1; m_left <= 20; m_exp <= cur_pt; end
        1: if (m_left == 1) begin m_phase <= 2; m_out <= m_exp; end
           else m_left <= m_left - 1;
        default: if (bus.out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    checks++;
    if (bus.in_ready !== (m_phase == 0) || bus.out_valid !== (m_phase == 2) || dout !== m_out) begin
      errors++;
      $display("FAIL cycle_compare cyc=%0d in_ready=%b exp %b out_valid=%b exp %b out=%h exp %h",
               cyc, bus.in_ready, (m_phase == 0), bus.out_valid, (m_phase == 2), dout, m_out);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [127:0] ct, input logic [127:0] key);
    {bus.IN_DATA3, bus.IN_DATA2, bus.IN_DATA1, bus.IN_DATA0} = ct;
    {bus.IN_KEY3, bus.IN_KEY2, bus.IN_KEY1, bus.IN_KEY0} = key;
  endtask

  // returns at the falling edge right after the accept edge
  task automatic send(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt);
    int n;
    n = 0;
    @(negedge clk);
    drive(ct, key);
    cur_pt = pt;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready never rose, got %b expected 1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: got %b expected 1", bus.out_valid);
    end
    lat = cyc - acc_cyc;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, a1, a2, stall;
    logic [7:0]   p, q, x;
    logic [127:0] k, pt;

    reset_n       = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive('0, '0);

    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;

    chk("model_sbox_53", {120'h0, sbox[8'h53]}, 128'hed);
    chk("model_sbox_ff", {120'h0, sbox[8'hff]}, 128'h16);
    chk("model_enc_c1", aes_enc(C1_PT, C1_KEY), C1_CT);
    chk("model_enc_appb", aes_enc(B_PT, B_KEY), B_CT);

    #1 reset_n = 1'b0;
    #1;
    chk("reset_in_ready", {127'h0, bus.in_ready}, 128'h1);
    chk("reset_out_valid", {127'h0, bus.out_valid}, 128'h0);
    chk("reset_out_data", dout, '0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    send(C1_CT, C1_KEY, C1_PT);
    wait_out(lat);
    chk("c1_latency", 128'(lat), 128'd20);
    chk("c1_plaintext", dout, C1_PT);
    @(negedge clk);

    send(B_CT, B_KEY, B_PT);
    wait_out(lat);
    chk("appb_latency", 128'(lat), 128'd20);
    chk("appb_plaintext", dout, B_PT);
    @(negedge clk);

    send(C1_CT, C1_KEY, C1_PT);
    a1 = acc_cyc;
    send(B_CT, B_KEY, B_PT);
    a2 = acc_cyc;
    chk("b2b_accept_spacing", 128'(a2 - a1), 128'd22);
    wait_out(lat);
    chk("b2b_second_plaintext", dout, B_PT);
    @(negedge clk);

    bus.out_ready = 1'b0;
    send(C1_CT, C1_KEY, C1_PT);
    wait_out(lat);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {127'h0, bus.out_valid}, 128'h1);
      chk("bp_in_ready", {127'h0, bus.in_ready}, 128'h0);
      chk("bp_out_data", dout, C1_PT);
      bus.in_valid = (i % 3 == 0);
      drive({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", {127'h0, bus.out_valid}, 128'h0);
    chk("bp_release_in_ready", {127'h0, bus.in_ready}, 128'h1);
    chk("bp_release_out_held", dout, C1_PT);

    send(B_CT, B_KEY, B_PT);
    repeat (15) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_in_ready", {127'h0, bus.in_ready}, 128'h1);
    chk("midreset_out_valid", {127'h0, bus.out_valid}, 128'h0);
    chk("midreset_out_data", dout, '0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    send(C1_CT, C1_KEY, C1_PT);
    wait_out(lat);
    chk("after_reset_latency", 128'(lat), 128'd20);
    chk("after_reset_plaintext", dout, C1_PT);
    @(negedge clk);

    for (int n = 0; n < 1000; n++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      stall = $urandom_range(0, 3);
      bus.out_ready = (stall == 0);
      send(aes_enc(pt, k), k, pt);
      wait_out(lat);
      chk("loopback_plaintext", dout, pt);
      repeat (stall) @(negedge clk);
      bus.out_ready = 1'b1;
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
